// File: rtl/controller_reader_if.sv
// controller_reader_if
//   Groups the controller-side serial lines and the parallel button word of
//   controller_reader into one bundle.
//   master : the reader (drives ctrl_latch, ctrl_clk, controller_inputs,
//            frame_done; receives ctrl_data_p1/p2)
//   slave  : the controllers plus the downstream consumer (opposite directions)
//   Signals:
//     ctrl_data_p1/p2    serial data from P1/P2, active-low, asynchronous
//     ctrl_latch         shared latch strobe to both controllers
//     ctrl_clk           shared serial clock to both controllers
//     controller_inputs  16-bit button word, 1 = pressed, P1 in [15:8]
//     frame_done         1-cycle strobe when controller_inputs updates
interface controller_reader_if;
  logic        ctrl_data_p1;
  logic        ctrl_data_p2;
  logic        ctrl_latch;
  logic        ctrl_clk;
  logic [15:0] controller_inputs;
  logic        frame_done;

  modport master (
    input  ctrl_data_p1,
    input  ctrl_data_p2,
    output ctrl_latch,
    output ctrl_clk,
    output controller_inputs,
    output frame_done
  );

  modport slave (
    output ctrl_data_p1,
    output ctrl_data_p2,
    input  ctrl_latch,
    input  ctrl_clk,
    input  controller_inputs,
    input  frame_done
  );
endinterface

// File: rtl/controller_reader.sv
// controller_reader
//   Polls two NES-style serial controllers once per POLL_CYC cycles and
//   publishes a 16-bit button word (1 = pressed). P1 in [15:8], P2 in [7:0];
//   per byte MSB..LSB: A, B, Select, Start, Up, Down, Left, Right.
// Ports:
//   clk   in  system clock
//   nrst  in  asynchronous active-low reset
//   bus   controller_reader_if.master
//         (ctrl_data_p1/p2 in, ctrl_latch/ctrl_clk/controller_inputs/frame_done out)
// Parameters:
//   HALF_CYC  clk cycles per controller half-period (>= 3)
//   POLL_CYC  clk cycles between frame starts (>= 1)
// Build option:
//   CTRL_DEBOUNCE_EN  when defined, a frame is published only if it matches
//                     the previous raw frame word.
module controller_reader #(
  parameter int HALF_CYC = 4,
  parameter int POLL_CYC = 166667
) (
  input  logic                 clk,
  input  logic                 nrst,
  controller_reader_if.master  bus
);

  localparam int PW = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
  localparam int HW = $clog2(2 * HALF_CYC);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYC - 1);
  localparam logic [HW-1:0] LATCH_LAST = HW'(2 * HALF_CYC - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_GAP, S_HIGH, S_LOW, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          pend_q, pend_d;
  logic [HW-1:0] ph_q, ph_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sr1_q, sr1_d, sr2_q, sr2_d;
  logic [1:0]    sync1_q, sync2_q;
  logic [15:0]   cin_q, cin_d;
  logic          fd_q, fd_d;
  logic          latch_q, latch_d;
  logic          cclk_q, cclk_d;
  logic [15:0]   word;
  logic          upd;
  logic          shift;
  logic          wrap, half_end, start;

  assign wrap     = (poll_q == POLL_LAST);
  assign half_end = (ph_q == HALF_LAST);
  // A wrap that lands mid-frame is remembered; DONE can launch the next frame directly.
  assign start    = ((state_q == S_IDLE) || (state_q == S_DONE)) && (wrap || pend_q);

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      poll_q  <= '0;
      pend_q  <= 1'b0;
      ph_q    <= '0;
      bit_q   <= '0;
      sr1_q   <= '0;
      sr2_q   <= '0;
      sync1_q <= '1;
      sync2_q <= '1;
      cin_q   <= '0;
      fd_q    <= 1'b0;
      latch_q <= 1'b0;
      cclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
      pend_q  <= pend_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      sr1_q   <= sr1_d;
      sr2_q   <= sr2_d;
      sync1_q <= {sync1_q[0], bus.ctrl_data_p1};
      sync2_q <= {sync2_q[0], bus.ctrl_data_p2};
      cin_q   <= cin_d;
      fd_q    <= fd_d;
      latch_q <= latch_d;
      cclk_q  <= cclk_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q + HW'(1);
    bit_d   = bit_q;
    shift   = 1'b0;
    poll_d  = wrap ? '0 : poll_q + PW'(1);
    pend_d  = start ? 1'b0 : (pend_q | wrap);
    unique case (state_q)
      S_IDLE: begin
        ph_d = '0;
        if (start) state_d = S_LATCH;
      end
      S_LATCH: begin
        if (ph_q == LATCH_LAST) begin
          state_d = S_GAP;
          ph_d    = '0;
        end
      end
      S_GAP: begin
        if (half_end) begin
          shift   = 1'b1;
          bit_d   = 3'd1;
          state_d = S_HIGH;
          ph_d    = '0;
        end
      end
      S_HIGH: begin
        if (half_end) begin
          state_d = S_LOW;
          ph_d    = '0;
        end
      end
      S_LOW: begin
        if (half_end) begin
          shift = 1'b1;
          ph_d  = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = S_DONE;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = S_HIGH;
          end
        end
      end
      S_DONE: begin
        ph_d    = '0;
        state_d = start ? S_LATCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // First bit shifted (A) ends up in bit 7 after eight shifts.
  assign sr1_d = shift ? {sr1_q[6:0], sync1_q[1]} : sr1_q;
  assign sr2_d = shift ? {sr2_q[6:0], sync2_q[1]} : sr2_q;
  assign word  = ~{sr1_d, sr2_d};

`ifdef CTRL_DEBOUNCE_EN
  logic [15:0] raw_q, raw_d;

  assign raw_d = (state_d == S_DONE) ? word : raw_q;
  assign upd   = (state_d == S_DONE) && (word == raw_q);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) raw_q <= '0;
    else       raw_q <= raw_d;
  end
`else
  assign upd = (state_d == S_DONE);
`endif

  // Outputs are decoded from the next state and registered, so each output
  // lines up with the state it belongs to without combinational glitches.
  always_comb begin
    latch_d = (state_d == S_LATCH);
    cclk_d  = (state_d == S_HIGH);
    fd_d    = upd;
    cin_d   = upd ? word : cin_q;
  end

  assign bus.ctrl_latch        = latch_q;
  assign bus.ctrl_clk          = cclk_q;
  assign bus.controller_inputs = cin_q;
  assign bus.frame_done        = fd_q;

endmodule

// File: tb/tb_controller_reader.sv
module tb_controller_reader;

`ifdef CTRL_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  controller_reader_if u_if();

  controller_reader #(.HALF_CYC(4), .POLL_CYC(100)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (u_if)
  );

  // 4021-style controller models: parallel load while latch is high,
  // shift toward bit 7 on ctrl_clk rise, serial out = bit 7, released = 1.
  logic [7:0] btn1 = 8'h00;
  logic [7:0] btn2 = 8'h00;
  logic [7:0] sh1  = 8'hFF;
  logic [7:0] sh2  = 8'hFF;
  logic       pc   = 1'b0;

  always @(posedge clk) begin
    pc <= u_if.ctrl_clk;
    if (u_if.ctrl_latch) begin
      sh1 <= ~btn1;
      sh2 <= ~btn2;
    end else if (u_if.ctrl_clk && !pc) begin
      sh1 <= {sh1[6:0], 1'b1};
      sh2 <= {sh2[6:0], 1'b1};
    end
  end

  assign u_if.ctrl_data_p1 = sh1[7];
  assign u_if.ctrl_data_p2 = sh2[7];

  // Waveform monitor: pulse count per frame, pulse high/low lengths, overlap.
  int   rises   = 0;
  int   hirun   = 0;
  int   lowrun  = 0;
  int   badlen  = 0;
  int   overlap = 0;
  logic had     = 1'b0;
  logic mprev_c = 1'b0;
  logic mprev_l = 1'b0;

  always @(negedge clk) begin
    mprev_c <= u_if.ctrl_clk;
    mprev_l <= u_if.ctrl_latch;
    if (!nrst) begin
      rises  <= 0;
      hirun  <= 0;
      lowrun <= 0;
      had    <= 1'b0;
    end else begin
      if (u_if.ctrl_clk && u_if.ctrl_latch) overlap <= overlap + 1;
      if (u_if.ctrl_latch && !mprev_l) begin
        rises  <= 0;
        had    <= 1'b0;
        lowrun <= 0;
      end else if (u_if.ctrl_clk && !mprev_c) begin
        rises <= rises + 1;
        hirun <= 1;
        if (had && lowrun != 4) badlen <= badlen + 1;
      end else if (u_if.ctrl_clk) begin
        hirun <= hirun + 1;
      end else if (mprev_c) begin
        lowrun <= 1;
        had    <= 1'b1;
        if (hirun != 4) badlen <= badlen + 1;
      end else begin
        lowrun <= lowrun + 1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int now     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the t-th rising edge since reset release.
  task automatic until_cyc(input int t);
    while (now < t) begin
      @(posedge clk);
      now++;
    end
    #1;
  endtask

  // End of frame k (k >= 1) after release: latch at 100k, DONE at 100k+68.
  task automatic frame(input int k);
    until_cyc(100 * k + 68);
  endtask

  task automatic chk_wave(input string tag);
    chk({tag, "_pulses"},  32'(rises),   32'd7);
    chk({tag, "_lengths"}, 32'(badlen),  32'd0);
    chk({tag, "_overlap"}, 32'(overlap), 32'd0);
  endtask

  initial begin
    // 1: reset state, idle lines, first frame timing
    repeat (3) @(posedge clk);
    #1;
    chk("rst_latch", 32'(u_if.ctrl_latch), 32'd0);
    chk("rst_cclk",  32'(u_if.ctrl_clk), 32'd0);
    chk("rst_word",  32'(u_if.controller_inputs), 32'h0000);
    chk("rst_fd",    32'(u_if.frame_done), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    now  = 0;
    until_cyc(99);  chk("latch_before", 32'(u_if.ctrl_latch), 32'd0);
    until_cyc(100); chk("latch_rise",   32'(u_if.ctrl_latch), 32'd1);
                    chk("cclk_in_latch", 32'(u_if.ctrl_clk), 32'd0);
    until_cyc(107); chk("latch_hold",   32'(u_if.ctrl_latch), 32'd1);
    until_cyc(108); chk("latch_fall",   32'(u_if.ctrl_latch), 32'd0);
    until_cyc(112); chk("cclk_rise",    32'(u_if.ctrl_clk), 32'd1);
    until_cyc(116); chk("cclk_fall",    32'(u_if.ctrl_clk), 32'd0);
    until_cyc(167); chk("fd_before",    32'(u_if.frame_done), 32'd0);
    until_cyc(168); chk("f1_fd",        32'(u_if.frame_done), 32'd1);
                    chk("f1_word",      32'(u_if.controller_inputs), 32'h0000);
    until_cyc(169); chk("f1_fd_off",    32'(u_if.frame_done), 32'd0);
    chk_wave("f1");

    // 2: P1 presses A
    btn1 = 8'h80;
    frame(2);
    chk("f2_word", 32'(u_if.controller_inputs), DEB ? 32'h0000 : 32'h8000);
    chk("f2_fd",   32'(u_if.frame_done), DEB ? 32'd0 : 32'd1);
    frame(3);
    chk("f3_word", 32'(u_if.controller_inputs), 32'h8000);
    chk("f3_fd",   32'(u_if.frame_done), 32'd1);
    until_cyc(369); chk("f3_fd_off", 32'(u_if.frame_done), 32'd0);

    // 3: P1 Start+Up, P2 B+Right
    btn1 = 8'h18;
    btn2 = 8'h41;
    until_cyc(420); chk("f4_mid_hold", 32'(u_if.controller_inputs), 32'h8000);
    frame(4);
    chk("f4_word", 32'(u_if.controller_inputs), DEB ? 32'h8000 : 32'h1841);
    frame(5);
    chk("f5_word", 32'(u_if.controller_inputs), 32'h1841);
    chk("f5_fd",   32'(u_if.frame_done), 32'd1);
    btn1 = 8'h00;
    btn2 = 8'h00;
    until_cyc(667); chk("f6_hold", 32'(u_if.controller_inputs), 32'h1841);
    frame(6);
    chk("f6_word", 32'(u_if.controller_inputs), DEB ? 32'h1841 : 32'h0000);
    // 4: waveform shape
    until_cyc(669);
    chk_wave("f6");

    // 6: P1 alternates A / none
    frame(7);
    chk("f7_word", 32'(u_if.controller_inputs), 32'h0000);
    chk("f7_fd",   32'(u_if.frame_done), 32'd1);
    btn1 = 8'h80;
    frame(8);
    chk("f8_word", 32'(u_if.controller_inputs), DEB ? 32'h0000 : 32'h8000);
    btn1 = 8'h00;
    frame(9);
    chk("f9_word", 32'(u_if.controller_inputs), 32'h0000);
    chk("f9_fd",   32'(u_if.frame_done), DEB ? 32'd0 : 32'd1);
    btn1 = 8'h80;
    frame(10);
    chk("f10_word", 32'(u_if.controller_inputs), DEB ? 32'h0000 : 32'h8000);
    frame(11);
    chk("f11_word", 32'(u_if.controller_inputs), 32'h8000);
    chk("f11_fd",   32'(u_if.frame_done), 32'd1);

    // 5: reset during the 3rd ctrl_clk pulse of frame 12
    until_cyc(1229); chk("r_cclk_high", 32'(u_if.ctrl_clk), 32'd1);
    nrst = 1'b0;
    #1;
    chk("r_latch", 32'(u_if.ctrl_latch), 32'd0);
    chk("r_cclk",  32'(u_if.ctrl_clk), 32'd0);
    chk("r_word",  32'(u_if.controller_inputs), 32'h0000);
    chk("r_fd",    32'(u_if.frame_done), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("r_fd_hold", 32'(u_if.frame_done), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    now  = 0;
    until_cyc(99);  chk("r2_latch_before", 32'(u_if.ctrl_latch), 32'd0);
    until_cyc(100); chk("r2_latch_rise",   32'(u_if.ctrl_latch), 32'd1);
    frame(1);
    chk("r2_fd",   32'(u_if.frame_done), DEB ? 32'd0 : 32'd1);
    chk("r2_word", 32'(u_if.controller_inputs), DEB ? 32'h0000 : 32'h8000);
    until_cyc(169);
    chk_wave("r2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
